// File: rtl/mor1kx_store_buffer_drain.sv
// ---------------------------------------------------------------------------
// mor1kx_store_buffer_drain
//
// Purpose:
//   Pops entries from the store buffer one at a time and writes each one out
//   as a single Wishbone classic write cycle. Atomic entries whose reservation
//   has been lost are dropped without touching the bus and reported with a
//   one-cycle atomic_fail_o pulse. Bus errors latch the address and store PC
//   of the failing entry and raise a one-cycle bus_err_o pulse.
//
//   Per-entry sequence: IDLE (pop) -> LOAD (entry fields valid) ->
//   WRITE (bus cycle held until ack/err) -> IDLE. A zero-wait-state slave
//   therefore drains one entry every three cycles.
//
// Optional feature:
//   OR1K_SB_DRAIN_TIMEOUT_EN -- when defined, an 8-bit watchdog abandons a
//   WRITE that has not terminated after TIMEOUT_CYCLES cycles and reports it
//   as a bus error. When undefined, WRITE waits for the slave indefinitely.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable_i            drain permitted (gates new pops only)
//   sb_empty_i          store buffer empty flag
//   sb_adr_i/dat_i/pc_i entry address, data and store PC (valid in LOAD)
//   sb_bsel_i           entry byte select
//   sb_atomic_i         entry is an atomic store
//   sb_read_o           one-cycle pop strobe to the store buffer
//   atomic_ok_i         reservation still valid for an atomic entry
//   wbm_*               Wishbone classic master, write only
//   bus_err_o           one-cycle error pulse, after termination
//   err_adr_o/err_pc_o  address/PC of the last failing entry
//   atomic_fail_o       one-cycle pulse: atomic entry dropped
//   drained_o           store buffer empty and drain engine idle
// ---------------------------------------------------------------------------
module mor1kx_store_buffer_drain #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable_i,
  input  logic                                sb_empty_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]     sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]     sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]     sb_pc_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0]   sb_bsel_i,
  input  logic                                sb_atomic_i,
  output logic                                sb_read_o,
  input  logic                                atomic_ok_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]     wbm_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]     wbm_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0]   wbm_sel_o,
  output logic                                wbm_we_o,
  output logic                                wbm_cyc_o,
  output logic                                wbm_stb_o,
  input  logic                                wbm_ack_i,
  input  logic                                wbm_err_i,
  output logic                                bus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]     err_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]     err_pc_o,
  output logic                                atomic_fail_o,
  output logic                                drained_o
);

  localparam int W = OPTION_OPERAND_WIDTH;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [W-1:0]   entry_pc;     // store PC of the entry currently on the bus
  logic           issue;        // LOAD cycle that starts a bus write
  logic           wr_done;      // WRITE terminates this cycle (any reason)
  logic           wr_fail;      // termination is an error (err or watchdog)
  logic           timeout_hit;  // watchdog expires this cycle

  // -------------------------------------------------------------------------
  // Optional bus watchdog
  // -------------------------------------------------------------------------
`ifdef OR1K_SB_DRAIN_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Cleared while loading the entry, so the first WRITE cycle sees zero and
  // the limit is reached after exactly TIMEOUT_CYCLES WRITE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= 8'd0;
    end else if (state == LOAD) begin
      to_cnt <= 8'd0;
    end else if (state == WRITE) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign timeout_hit = (state == WRITE) && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and strobe decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    sb_read_o = 1'b0;
    issue     = 1'b0;
    wr_done   = 1'b0;
    wr_fail   = 1'b0;

    unique case (state)
      IDLE: begin
        // Pop is only ever issued from IDLE, which keeps one entry in flight.
        if (enable_i && !sb_empty_i) begin
          sb_read_o = 1'b1;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        if (sb_atomic_i && !atomic_ok_i) begin
          state_nxt = DROP;
        end else begin
          issue     = 1'b1;
          state_nxt = WRITE;
        end
      end

      WRITE: begin
        // err wins over a simultaneous ack; a real ack on the last watchdog
        // cycle still counts as a successful write.
        if (wbm_err_i) begin
          wr_done = 1'b1;
          wr_fail = 1'b1;
        end else if (wbm_ack_i) begin
          wr_done = 1'b1;
        end else if (timeout_hit) begin
          wr_done = 1'b1;
          wr_fail = 1'b1;
        end
        if (wr_done) begin
          state_nxt = IDLE;
        end
      end

      DROP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign atomic_fail_o = (state == DROP);
  assign drained_o     = sb_empty_i && (state == IDLE);

  // -------------------------------------------------------------------------
  // State, bus and error registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      entry_pc  <= '0;
      bus_err_o <= 1'b0;
      err_adr_o <= '0;
      err_pc_o  <= '0;
    end else begin
      state     <= state_nxt;
      bus_err_o <= wr_fail;

      // The bus output registers double as the captured entry fields, so
      // they stay frozen for the whole WRITE.
      if (issue) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= 1'b1;
        wbm_adr_o <= sb_adr_i;
        wbm_dat_o <= sb_dat_i;
        wbm_sel_o <= sb_bsel_i;
        entry_pc  <= sb_pc_i;
      end else if (wr_done) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
      end

      if (wr_fail) begin
        err_adr_o <= wbm_adr_o;
        err_pc_o  <= entry_pc;
      end
    end
  end

endmodule
